instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the ROM address width.
REQ-002 The module SHALL have parameter RESET_PC, default 8'h00, giving the PC value loaded at reset and on every start.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The module SHALL have port clk, input, 1 bit: rising-edge system clock.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: begin fetching from RESET_PC; honoured only in IDLE or HALT.
REQ-007 The module SHALL have port rom_read, output, 1 bit: read strobe to the instruction ROM.
REQ-008 The module SHALL have port rom_addr, output, ADDR_W bits: ROM address.
REQ-009 The module SHALL have port rom_data, input, 16 bits: registered ROM output, valid one cycle after rom_read.
REQ-010 The module SHALL have port instr_valid, output, 1 bit: decoded instruction is available.
REQ-011 The module SHALL have port instr_ready, input, 1 bit: the consumer accepts the instruction.
REQ-012 The module SHALL have outputs instr[15:0], opcode[3:0], dst[5:0], src[5:0], dst_is_acc (1 bit) and pc_out (ADDR_W bits).
REQ-013 The module SHALL have inputs jump_en (1 bit) and jump_addr (ADDR_W bits): a PC override sampled on handshake only.
REQ-014 The module SHALL have port halted, output, 1 bit: the fetch unit is stopped on a zero instruction.

Function
REQ-015 The module SHALL implement states IDLE, FETCH, CAPTURE, ISSUE and HALT.
REQ-016 In IDLE, start=1 SHALL set pc to RESET_PC and go to FETCH; otherwise the module SHALL stay in IDLE.
REQ-017 In FETCH, rom_read=1 and rom_addr=pc SHALL hold for exactly one cycle, then the module SHALL go to CAPTURE; rom_read SHALL be 0 in every other state.
REQ-018 In CAPTURE, the module SHALL latch rom_data into instr; if rom_data[15:12]==4'b0000 it SHALL go to HALT, otherwise it SHALL set pc to pc+1 (mod 2^ADDR_W) and go to ISSUE.
REQ-019 Decode SHALL be opcode=instr[15:12], dst=instr[11:6], src=instr[5:0], and dst_is_acc=(dst==6'h3F); decode is combinational from the instr register.
REQ-020 pc_out SHALL equal the address the current instr was fetched from.
REQ-021 In ISSUE, instr_valid SHALL be 1, and instr and all decode outputs SHALL be stable until the handshake (instr_valid & instr_ready).
REQ-022 On handshake, the module SHALL go to FETCH; if jump_en=1 in the same cycle, pc SHALL load jump_addr instead of keeping the incremented value.
REQ-023 jump_en outside the handshake cycle SHALL be ignored.
REQ-024 Latency from start to first instr_valid SHALL be 3 cycles; with instr_ready held high, throughput SHALL be one instruction per 3 cycles.
REQ-025 PC wrap: fetching at address 0xFF SHALL increment pc to 0x00 with no error flag.
REQ-026 In HALT, halted=1 and instr_valid=0 SHALL hold, and no ROM reads SHALL occur; start=1 SHALL reload RESET_PC and go to FETCH.
REQ-027 start asserted in FETCH, CAPTURE or ISSUE SHALL be ignored.
REQ-028 Opcodes other than 0000 SHALL pass through undecoded-by-legality; this unit SHALL raise no illegal-opcode trap.

Reset
REQ-029 While rst=1, regardless of clk, the module SHALL force state=IDLE, pc=RESET_PC, instr=16'h0000, rom_read=0, rom_addr=RESET_PC, instr_valid=0, halted=0 and pc_out=RESET_PC.
REQ-030 Reset asserted mid-fetch or mid-ISSUE SHALL abort immediately, and the pending instruction SHALL be discarded, not issued.
REQ-031 After rst deasserts, the module SHALL stay in IDLE until start=1.

Verification
REQ-032 ROM model holds 0x00=C041, 0x01=C082, 0x02=2081; start with instr_ready=1 -> instr_valid at cycles 3, 6, 9 with opcode C/C/2, dst 01/02/02, src 01/02/01, pc_out 00/01/02.
REQ-033 ROM 0x03=CFCA; fetch reaches it -> opcode=C, dst=3F, dst_is_acc=1, src=0A.
REQ-034 instr_ready held low for 5 cycles in ISSUE -> instr_valid stays 1, instr unchanged, rom_read stays 0; ready=1 -> FETCH at next pc.
REQ-035 Handshake with jump_en=1 and jump_addr=8'h10 (ROM 0x10=DFC1) -> next rom_addr=0x10, opcode=D, pc_out=0x10.
REQ-036 ROM address 0x0C=0000 -> halted=1 after CAPTURE, instr_valid never asserts for it, no further rom_read; start -> rom_addr=0x00.
REQ-037 rst pulsed while in ISSUE, and separately with pc=0xFF -> outputs return to reset values at once, and pc wraps 0xFF->0x00 in the non-reset run.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches 16-bit instructions from a registered ROM one at a time, decodes the
// fixed fields combinationally and offers each instruction to a consumer with
// a valid/ready handshake. Fetching begins at RESET_PC on start and stops in
// HALT when an instruction with opcode 4'b0000 is read.
// The consumer may redirect the PC with jump_en/jump_addr during the handshake.
//
// One instruction takes three cycles: FETCH (ROM strobe), CAPTURE (ROM data
// latched), then ISSUE (held until accepted).
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin fetching at RESET_PC (honoured in IDLE and HALT only)
//   rom_read     ROM read strobe, high only in FETCH
//   rom_addr     ROM address (the current PC)
//   rom_data     registered ROM output, valid the cycle after rom_read
//   instr_valid  instruction available to the consumer (ISSUE)
//   instr_ready  consumer accepts the instruction
//   instr        captured instruction word
//   opcode       instr[15:12]
//   dst          instr[11:6]
//   src          instr[5:0]
//   dst_is_acc   dst addresses the accumulator (6'h3F)
//   pc_out       address the current instr was fetched from
//   jump_en      load jump_addr into the PC on the handshake
//   jump_addr    jump target
//   halted       stopped on a zero-opcode instruction
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              rom_read,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [15:0]       instr,
   output logic [3:0]        opcode,
   output logic [5:0]        dst,
   output logic [5:0]        src,
   output logic              dst_is_acc,
   output logic [ADDR_W-1:0] pc_out,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPTURE,
      S_ISSUE,
      S_HALT
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] pc;        // next address to fetch
   logic [ADDR_W-1:0] fetch_pc;  // address the held instruction came from
   logic [15:0]       instr_q;
   logic              handshake;
   logic              halt_op;

   assign handshake = (state == S_ISSUE) && instr_ready;
   assign halt_op   = (rom_data[15:12] == 4'b0000);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and control outputs
   // -------------------------------------------------------------------------
   // NOTE: every output of this block is given a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_next  = state;
      rom_read    = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_next = S_FETCH;
         end
         S_FETCH: begin
            rom_read   = 1'b1;
            state_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_next = halt_op ? S_HALT : S_ISSUE;
         end
         S_ISSUE: begin
            instr_valid = 1'b1;
            if (instr_ready) state_next = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) state_next = S_FETCH;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // PC and instruction registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         fetch_pc <= RESET_PC;
         instr_q  <= 16'h0000;
      end else begin
         unique case (state)
            S_IDLE, S_HALT: begin
               if (start) pc <= RESET_PC;
            end
            S_CAPTURE: begin
               instr_q  <= rom_data;
               fetch_pc <= pc;
               // The PC stays on a halting instruction; restart reloads it.
               if (!halt_op) pc <= pc + ADDR_W'(1);
            end
            S_ISSUE: begin
               // The jump is only looked at when the instruction is accepted.
               if (handshake && jump_en) pc <= jump_addr;
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs and combinational decode
   // -------------------------------------------------------------------------
   assign rom_addr   = pc;
   assign pc_out     = fetch_pc;
   assign instr      = instr_q;
   assign opcode     = instr_q[15:12];
   assign dst        = instr_q[11:6];
   assign src        = instr_q[5:0];
   assign dst_is_acc = (instr_q[11:6] == 6'h3F);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit with a registered 256x16 ROM model. A directed
// table covers the documented fetch, stall, jump and halt sequences; short
// hand-written sequences cover asynchronous reset and PC wrap; a randomized
// run is compared every cycle against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam int          ADDR_W   = 8;
   localparam logic [7:0]  RESET_PC = 8'h00;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        rom_read;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [5:0]  dst;
   logic [5:0]  src;
   logic        dst_is_acc;
   logic [7:0]  pc_out;
   logic        jump_en;
   logic [7:0]  jump_addr;
   logic        halted;

   int check_cnt = 0;
   int pass_cnt  = 0;

   instr_fetch_unit #(
      .ADDR_W  (ADDR_W),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rom_read   (rom_read),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr      (instr),
      .opcode     (opcode),
      .dst        (dst),
      .src        (src),
      .dst_is_acc (dst_is_acc),
      .pc_out     (pc_out),
      .jump_en    (jump_en),
      .jump_addr  (jump_addr),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   // Registered ROM: data appears the cycle after the read strobe.
   logic [15:0] rom [256];
   always @(posedge clk) begin
      if (rom_read) rom_data <= rom[rom_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: tracks which address is fetched next, how many cycles
   // remain until the pending fetch is captured, and which word is on offer.
   // ---------------------------------------------------------------------------
   typedef enum {M_IDLE, M_BUSY, M_ISSUE, M_HALT} mode_t;
   mode_t       m_mode;
   int          m_cnt;
   int          m_pc;
   logic [15:0] m_word;
   int          m_word_pc;

   task automatic m_reset();
      m_mode    = M_IDLE;
      m_cnt     = 0;
      m_pc      = RESET_PC;
      m_word    = 16'h0000;
      m_word_pc = RESET_PC;
   endtask

   task automatic m_step(input logic s, input logic r, input logic je, input logic [7:0] ja);
      case (m_mode)
         M_IDLE, M_HALT: begin
            if (s) begin
               m_pc   = RESET_PC;
               m_mode = M_BUSY;
               m_cnt  = 2;
            end
         end
         M_BUSY: begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
               m_word    = rom[m_pc];
               m_word_pc = m_pc;
               if ((m_word >> 12) == 0) begin
                  m_mode = M_HALT;
               end else begin
                  m_pc   = (m_pc + 1) % 256;
                  m_mode = M_ISSUE;
               end
            end
         end
         M_ISSUE: begin
            if (r) begin
               if (je) m_pc = ja;
               m_mode = M_BUSY;
               m_cnt  = 2;
            end
         end
         default: ;
      endcase
   endtask

   task automatic m_check();
      logic exp_read;
      exp_read = (m_mode == M_BUSY) && (m_cnt == 2);
      check("rom_read", rom_read, exp_read);
      if (exp_read) check("rom_addr", rom_addr, m_pc);
      check("instr_valid", instr_valid, m_mode == M_ISSUE);
      check("halted", halted, m_mode == M_HALT);
      if (m_mode == M_ISSUE) begin
         check("instr", instr, m_word);
         check("opcode", opcode, (m_word >> 12) & 15);
         check("dst", dst, (m_word >> 6) & 63);
         check("src", src, m_word & 63);
         check("dst_is_acc", dst_is_acc, ((m_word >> 6) & 63) == 63);
         check("pc_out", pc_out, m_word_pc);
      end
   endtask

   // One clock: drive inputs, advance DUT and model, compare.
   task automatic cycle(input logic s, input logic r, input logic je, input logic [7:0] ja);
      start       = s;
      instr_ready = r;
      jump_en     = je;
      jump_addr   = ja;
      @(posedge clk);
      #1;
      if (rst) m_reset();
      else     m_step(s, r, je, ja);
      m_check();
   endtask

   // Asynchronous reset assertion checked without any clock edge in between.
   task automatic async_reset_check(input string tag);
      rst = 1'b1;
      #2;
      check({tag, "_rom_read"}, rom_read, 1'b0);
      check({tag, "_rom_addr"}, rom_addr, RESET_PC);
      check({tag, "_instr_valid"}, instr_valid, 1'b0);
      check({tag, "_halted"}, halted, 1'b0);
      check({tag, "_instr"}, instr, 16'h0000);
      check({tag, "_pc_out"}, pc_out, RESET_PC);
      m_reset();
   endtask

   // ---------------------------------------------------------------------------
   // Directed table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        start;
      logic        ready;
      logic        je;
      logic [7:0]  ja;
      logic        exp_read;
      logic [7:0]  exp_addr;
      logic        exp_valid;
      logic        exp_halt;
      logic [15:0] exp_instr;
      logic [7:0]  exp_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic s, input logic r, input logic je, input logic [7:0] ja,
                              input logic rd, input logic [7:0] addr, input logic vl,
                              input logic hl, input logic [15:0] ins, input logic [7:0] pc);
      vec_t t;
      t.start = s;  t.ready = r;  t.je = je;  t.ja = ja;
      t.exp_read = rd;  t.exp_addr = addr;  t.exp_valid = vl;
      t.exp_halt = hl;  t.exp_instr = ins;  t.exp_pc = pc;
      return t;
   endfunction

   initial begin
      logic [15:0] w;
      logic [5:0]  d;

      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      rom[8'h00] = 16'hC041;
      rom[8'h01] = 16'hC082;
      rom[8'h02] = 16'h2081;
      rom[8'h03] = 16'hCFCA;
      rom[8'h0C] = 16'h0000;
      rom[8'h10] = 16'hDFC1;
      rom[8'hFF] = 16'h3A55;

      //               st rdy je ja      rd addr   vl hl instr     pc
      vecs.push_back(v(1, 1, 0, 8'h00,  1, 8'h00, 0, 0, 16'h0000, 8'h00)); // FETCH 00
      vecs.push_back(v(0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 16'h0000, 8'h00));
      vecs.push_back(v(0, 1, 0, 8'h00,  0, 8'h00, 1, 0, 16'hC041, 8'h00)); // cycle 3
      vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h01, 0, 0, 16'h0000, 8'h00));
      vecs.push_back(v(0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 16'h0000, 8'h00));
      vecs.push_back(v(0, 1, 0, 8'h00,  0, 8'h00, 1, 0, 16'hC082, 8'h01)); // cycle 6
      vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h02, 0, 0, 16'h0000, 8'h00));
      vecs.push_back(v(0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 16'h0000, 8'h00));
      vecs.push_back(v(0, 1, 0, 8'h00,  0, 8'h00, 1, 0, 16'h2081, 8'h02)); // cycle 9
      vecs.push_back(v(0, 0, 0, 8'h00,  0, 8'h00, 1, 0, 16'h2081, 8'h02)); // stall x5
      vecs.push_back(v(1, 0, 0, 8'h00,  0, 8'h00, 1, 0, 16'h2081, 8'h02)); // start ignored
      vecs.push_back(v(0, 0, 1, 8'h55,  0, 8'h00, 1, 0, 16'h2081, 8'h02)); // jump ignored
      vecs.push_back(v(0, 0, 0, 8'h00,  0, 8'h00, 1, 0, 16'h2081, 8'h02));
      vecs.push_back(v(0, 0, 0, 8'h00,  0, 8'h00, 1, 0, 16'h2081, 8'h02));
      vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h03, 0, 0, 16'h0000, 8'h00)); // next pc
      vecs.push_back(v(1, 1, 0, 8'h00,  0, 8'h00, 0, 0, 16'h0000, 8'h00));
      vecs.push_back(v(0, 0, 0, 8'h00,  0, 8'h00, 1, 0, 16'hCFCA, 8'h03)); // acc dst
      vecs.push_back(v(0, 1, 1, 8'h10,  1, 8'h10, 0, 0, 16'h0000, 8'h00)); // jump 10
      vecs.push_back(v(0, 1, 1, 8'h77,  0, 8'h00, 0, 0, 16'h0000, 8'h00));
      vecs.push_back(v(0, 0, 0, 8'h00,  0, 8'h00, 1, 0, 16'hDFC1, 8'h10));
      vecs.push_back(v(0, 1, 1, 8'h0C,  1, 8'h0C, 0, 0, 16'h0000, 8'h00)); // jump 0C
      vecs.push_back(v(0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 16'h0000, 8'h00));
      vecs.push_back(v(0, 1, 0, 8'h00,  0, 8'h00, 0, 1, 16'h0000, 8'h00)); // HALT
      vecs.push_back(v(0, 1, 0, 8'h00,  0, 8'h00, 0, 1, 16'h0000, 8'h00));
      vecs.push_back(v(0, 1, 1, 8'h20,  0, 8'h00, 0, 1, 16'h0000, 8'h00));
      vecs.push_back(v(1, 1, 0, 8'h00,  1, 8'h00, 0, 0, 16'h0000, 8'h00)); // restart

      // Power-on reset values, then idle until start.
      rst = 1'b1; start = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
      #2;
      check("por_rom_read", rom_read, 1'b0);
      check("por_rom_addr", rom_addr, RESET_PC);
      check("por_instr_valid", instr_valid, 1'b0);
      check("por_halted", halted, 1'b0);
      check("por_instr", instr, 16'h0000);
      check("por_pc_out", pc_out, RESET_PC);
      m_reset();
      cycle(0, 0, 0, 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h00);

      // Directed table.
      foreach (vecs[i]) begin
         start = vecs[i].start; instr_ready = vecs[i].ready;
         jump_en = vecs[i].je;  jump_addr = vecs[i].ja;
         @(posedge clk);
         #1;
         check($sformatf("t%0d_rom_read", i), rom_read, vecs[i].exp_read);
         if (vecs[i].exp_read) check($sformatf("t%0d_rom_addr", i), rom_addr, vecs[i].exp_addr);
         check($sformatf("t%0d_instr_valid", i), instr_valid, vecs[i].exp_valid);
         check($sformatf("t%0d_halted", i), halted, vecs[i].exp_halt);
         if (vecs[i].exp_valid) begin
            w = vecs[i].exp_instr;
            d = w[11:6];
            check($sformatf("t%0d_instr", i), instr, w);
            check($sformatf("t%0d_opcode", i), opcode, w[15:12]);
            check($sformatf("t%0d_dst", i), dst, d);
            check($sformatf("t%0d_src", i), src, w[5:0]);
            check($sformatf("t%0d_dst_is_acc", i), dst_is_acc, d == 6'h3F);
            check($sformatf("t%0d_pc_out", i), pc_out, vecs[i].exp_pc);
         end
      end

      // Reset in the middle of a fetch, then stay idle without start.
      async_reset_check("rst_fetch");
      cycle(0, 1, 0, 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 8'h40);

      // Reset while an instruction is on offer: it must never be issued.
      cycle(1, 0, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);
      check("pre_rst_issue_valid", instr_valid, 1'b1);
      async_reset_check("rst_issue");
      cycle(0, 1, 0, 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h00);
      cycle(1, 0, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);

      // PC wrap: fetch at 0xFF, then the next fetch is at 0x00.
      cycle(0, 1, 1, 8'hFF);
      check("wrap_fetch_ff", rom_addr, 8'hFF);
      cycle(0, 0, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);
      check("wrap_pc_out_ff", pc_out, 8'hFF);
      cycle(0, 1, 0, 8'h00);
      check("wrap_next_addr", rom_addr, 8'h00);
      check("wrap_next_read", rom_read, 1'b1);
      cycle(0, 0, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);
      cycle(0, 1, 1, 8'hFF);

      // Reset with pc=0xFF mid-fetch.
      async_reset_check("rst_pc_ff");
      cycle(0, 0, 0, 8'h00);
      rst = 1'b0;
      cycle(0, 0, 0, 8'h00);

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 3) == 0), 8'($urandom));
      end
      rst = 1'b0;
      cycle(0, 0, 0, 8'h00);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
